// File: rtl/uart_byte_packer.sv
// Packs BYTES_PER_WORD received UART bytes LSB-first into one word for the async FIFO write port.
// Latency: a completed word can raise fifo_w_en the cycle after its last byte; partial words go out on flush/idle timeout.
// Backpressure: fifo_full stalls the output register; bytes still fill the assembly register and are dropped (counted) once it is full.
module uart_byte_packer #(
    parameter int         BYTES_PER_WORD = 4,
    parameter int         TIMEOUT_CYCLES = 1024,
    parameter logic [7:0] PAD_BYTE       = 8'h00,
    localparam int        OUT_WIDTH      = 8 * BYTES_PER_WORD
) (
    input  logic                 wclk,
    input  logic                 wrst,
    input  logic                 rx_valid,
    input  logic [7:0]           rx_data,
    input  logic                 flush,
    input  logic                 fifo_full,
    output logic                 fifo_w_en,
    output logic [OUT_WIDTH-1:0] fifo_data,
    output logic                 packing,
    output logic                 overflow,
    output logic [15:0]          drop_count
);

    // Index must also hold the post-byte count, which can reach BYTES_PER_WORD.
    localparam int IDX_W  = $clog2(BYTES_PER_WORD + 1);
    localparam int IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(BYTES_PER_WORD - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [OUT_WIDTH-1:0] asm_q, asm_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 asm_full_q, asm_full_d;
    logic [OUT_WIDTH-1:0] out_q, out_d;
    logic                 out_vld_q, out_vld_d;
    logic                 flush_pend_q, flush_pend_d;
    logic [IDLE_W-1:0]    idle_q, idle_d;
    logic                 overflow_q, overflow_d;
    logic [15:0]          drop_cnt_q, drop_cnt_d;

    logic                 drain;
    logic                 out_free;
    logic                 accept;
    logic                 drop;
    logic                 complete;
    logic                 timeout_hit;
    logic                 flush_req;
    logic [IDX_W-1:0]     cnt_after;
    logic [OUT_WIDTH-1:0] asm_w;
    logic [OUT_WIDTH-1:0] padded;

    assign fifo_w_en  = out_vld_q & ~fifo_full;
    assign fifo_data  = out_q;
    assign packing    = (idx_q != '0);
    assign overflow   = overflow_q;
    assign drop_count = drop_cnt_q;

    // Next-state: byte intake, word hand-off to the output register, flush/timeout and drop accounting.
    always_comb begin
        asm_d        = asm_q;
        idx_d        = idx_q;
        asm_full_d   = asm_full_q;
        out_d        = out_q;
        flush_pend_d = flush_pend_q;
        overflow_d   = overflow_q;
        drop_cnt_d   = drop_cnt_q;

        drain       = out_vld_q & ~fifo_full;
        out_free    = ~out_vld_q | drain;
        out_vld_d   = out_vld_q & ~drain;
        accept      = rx_valid & ~asm_full_q;
        drop        = rx_valid & asm_full_q;
        complete    = accept & (idx_q == LAST_IDX);
        timeout_hit = (TIMEOUT_CYCLES != 0) && packing && !accept && (idle_q == IDLE_LAST);
        flush_req   = flush | timeout_hit | flush_pend_q;
        cnt_after   = accept ? idx_q + IDX_W'(1) : idx_q;

        // Byte lands in its lane before any flush looks at the word.
        asm_w = asm_q;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (accept && idx_q == IDX_W'(i)) begin
                asm_w[8*i +: 8] = rx_data;
            end
        end

        padded = asm_w;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (IDX_W'(i) >= cnt_after) begin
                padded[8*i +: 8] = PAD_BYTE;
            end
        end

        if (asm_full_q) begin
            // A stalled full word moves out as soon as the output register frees up.
            if (out_free) begin
                out_d      = asm_q;
                out_vld_d  = 1'b1;
                asm_full_d = 1'b0;
            end
            flush_pend_d = 1'b0;
        end else if (complete) begin
            asm_d = asm_w;
            idx_d = '0;
            if (out_free) begin
                out_d     = asm_w;
                out_vld_d = 1'b1;
            end else begin
                asm_full_d = 1'b1;
            end
            // A flush arriving with the completing byte has nothing left to push.
            flush_pend_d = 1'b0;
        end else begin
            asm_d = asm_w;
            idx_d = cnt_after;
            if (flush_req) begin
                if (cnt_after == '0) begin
                    flush_pend_d = 1'b0;
                end else if (out_free) begin
                    out_d        = padded;
                    out_vld_d    = 1'b1;
                    idx_d        = '0;
                    flush_pend_d = 1'b0;
                end else begin
                    flush_pend_d = 1'b1;
                end
            end
        end

        if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != 16'hFFFF) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end

        // Idle cycles are only counted while a partial word is waiting.
        if (accept || flush_req || !packing || TIMEOUT_CYCLES == 0) begin
            idle_d = '0;
        end else begin
            idle_d = idle_q + IDLE_W'(1);
        end
    end

    // State registers; reset drops any partial word without writing it.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            asm_q        <= '0;
            idx_q        <= '0;
            asm_full_q   <= 1'b0;
            out_q        <= '0;
            out_vld_q    <= 1'b0;
            flush_pend_q <= 1'b0;
            idle_q       <= '0;
            overflow_q   <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            asm_q        <= asm_d;
            idx_q        <= idx_d;
            asm_full_q   <= asm_full_d;
            out_q        <= out_d;
            out_vld_q    <= out_vld_d;
            flush_pend_q <= flush_pend_d;
            idle_q       <= idle_d;
            overflow_q   <= overflow_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

endmodule

// File: tb/tb_uart_byte_packer.sv
// Directed bench for uart_byte_packer with BYTES_PER_WORD=4, TIMEOUT_CYCLES=16, PAD_BYTE=0.
// Every FIFO write is logged with the edge count at which it became visible.
// Inputs change 1 ns after the rising edge; outputs are sampled there or on the falling edge.
module tb_uart_byte_packer;

    logic        wclk = 1'b0;
    logic        wrst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        flush;
    logic        fifo_full;
    logic        fifo_w_en;
    logic [31:0] fifo_data;
    logic        packing;
    logic        overflow;
    logic [15:0] drop_count;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int last_cyc;
    int b_cyc[8];

    logic [31:0] wr_dat[$];
    int          wr_cyc[$];

    uart_byte_packer #(
        .BYTES_PER_WORD (4),
        .TIMEOUT_CYCLES (16),
        .PAD_BYTE       (8'h00)
    ) dut (
        .wclk       (wclk),
        .wrst       (wrst),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .flush      (flush),
        .fifo_full  (fifo_full),
        .fifo_w_en  (fifo_w_en),
        .fifo_data  (fifo_data),
        .packing    (packing),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    always #5 wclk = ~wclk;

    always @(posedge wclk) cyc <= cyc + 1;

    always @(negedge wclk) begin
        if (fifo_w_en) begin
            wr_dat.push_back(fifo_data);
            wr_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic fl);
        rx_valid = 1'b1;
        rx_data  = b;
        flush    = fl;
        tick();
        rx_valid = 1'b0;
        flush    = 1'b0;
        last_cyc = cyc;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic clear_log();
        wr_dat.delete();
        wr_cyc.delete();
    endtask

    function automatic logic [31:0] wr_at(input int i);
        if (i < wr_dat.size()) return wr_dat[i];
        return 32'hxxxxxxxx;
    endfunction

    function automatic int cyc_at(input int i);
        if (i < wr_cyc.size()) return wr_cyc[i];
        return -1000;
    endfunction

    initial begin
        wrst      = 1'b1;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        flush     = 1'b0;
        fifo_full = 1'b0;
        idle(2);

        // Reset state
        check("rst_w_en",     {31'd0, fifo_w_en}, 32'd0);
        check("rst_data",     fifo_data,          32'd0);
        check("rst_packing",  {31'd0, packing},   32'd0);
        check("rst_overflow", {31'd0, overflow},  32'd0);
        check("rst_drop",     {16'd0, drop_count}, 32'd0);
        wrst = 1'b0;
        idle(2);

        // Eight bytes, one every 3 cycles: two full words, each written the cycle after its last byte
        clear_log();
        for (int i = 0; i < 8; i++) begin
            send_byte(8'(8'h11 * (i + 1)), 1'b0);
            b_cyc[i] = last_cyc;
            if (i == 2) check("pack_mid", {31'd0, packing}, 32'd1);
            idle(2);
        end
        idle(3);
        check("w1_count", wr_dat.size(), 32'd2);
        check("w1_data0", wr_at(0), 32'h44332211);
        check("w1_data1", wr_at(1), 32'h88776655);
        check("w1_lat0",  cyc_at(0) - b_cyc[3], 32'd0);
        check("w1_lat1",  cyc_at(1) - b_cyc[7], 32'd0);
        check("w1_drop",  {16'd0, drop_count}, 32'd0);

        // Explicit flush of a 3-byte partial word, then a no-op flush
        clear_log();
        send_byte(8'hA1, 1'b0);
        send_byte(8'hA2, 1'b0);
        send_byte(8'hA3, 1'b0);
        idle(1);
        do_flush();
        idle(2);
        check("fl_count",   wr_dat.size(), 32'd1);
        check("fl_data",    wr_at(0), 32'h00A3A2A1);
        check("fl_packing", {31'd0, packing}, 32'd0);
        do_flush();
        idle(3);
        check("fl_noop", wr_dat.size(), 32'd1);

        // Idle timeout: word loads 16 edges after the last byte's edge
        clear_log();
        send_byte(8'hB1, 1'b0);
        send_byte(8'hB2, 1'b0);
        idle(20);
        check("to_count", wr_dat.size(), 32'd1);
        check("to_data",  wr_at(0), 32'h0000B2B1);
        check("to_lat",   cyc_at(0) - last_cyc, 32'd16);

        // A byte in the 15th idle cycle restarts the count
        clear_log();
        send_byte(8'hC1, 1'b0);
        idle(14);
        send_byte(8'hC2, 1'b0);
        idle(20);
        check("tor_count", wr_dat.size(), 32'd1);
        check("tor_data",  wr_at(0), 32'h0000C2C1);
        check("tor_lat",   cyc_at(0) - last_cyc, 32'd16);

        // FIFO full, 12 back-to-back bytes: two words buffered, four bytes dropped
        clear_log();
        fifo_full = 1'b1;
        for (int i = 1; i <= 12; i++) send_byte(8'(i), 1'b0);
        idle(3);
        check("full_nowrite", wr_dat.size(), 32'd0);
        check("full_ovf",     {31'd0, overflow}, 32'd1);
        check("full_drop",    {16'd0, drop_count}, 32'd4);
        fifo_full = 1'b0;
        idle(4);
        check("full_count", wr_dat.size(), 32'd2);
        check("full_data0", wr_at(0), 32'h04030201);
        check("full_data1", wr_at(1), 32'h08070605);
        check("full_b2b",   cyc_at(1) - cyc_at(0), 32'd1);

        // Byte plus flush at index 2, then byte plus flush at index 3
        clear_log();
        send_byte(8'hE1, 1'b0);
        send_byte(8'hE2, 1'b0);
        send_byte(8'hE3, 1'b1);
        idle(3);
        check("bf_count", wr_dat.size(), 32'd1);
        check("bf_data",  wr_at(0), 32'h00E3E2E1);
        send_byte(8'hF1, 1'b0);
        send_byte(8'hF2, 1'b0);
        send_byte(8'hF3, 1'b0);
        send_byte(8'hF4, 1'b1);
        idle(4);
        check("bf_full_count", wr_dat.size(), 32'd2);
        check("bf_full_data",  wr_at(1), 32'hF4F3F2F1);
        check("bf_full_lat",   cyc_at(1) - last_cyc, 32'd0);

        // Reset mid-word discards the partial word and clears drop state
        clear_log();
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        wrst = 1'b1;
        tick();
        wrst = 1'b0;
        check("mr_packing", {31'd0, packing}, 32'd0);
        check("mr_ovf",     {31'd0, overflow}, 32'd0);
        check("mr_drop",    {16'd0, drop_count}, 32'd0);
        idle(20);
        check("mr_nowrite", wr_dat.size(), 32'd0);
        send_byte(8'h9A, 1'b0);
        send_byte(8'h9B, 1'b0);
        send_byte(8'h9C, 1'b0);
        send_byte(8'h9D, 1'b0);
        idle(3);
        check("mr_count", wr_dat.size(), 32'd1);
        check("mr_data",  wr_at(0), 32'h9D9C9B9A);

        // Flush while the output register is stalled stays pending until it frees
        clear_log();
        fifo_full = 1'b1;
        send_byte(8'h21, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h23, 1'b0);
        send_byte(8'h24, 1'b0);
        send_byte(8'h31, 1'b0);
        send_byte(8'h32, 1'b0);
        do_flush();
        idle(2);
        check("pend_nowrite", wr_dat.size(), 32'd0);
        fifo_full = 1'b0;
        idle(4);
        check("pend_count", wr_dat.size(), 32'd2);
        check("pend_data0", wr_at(0), 32'h24232221);
        check("pend_data1", wr_at(1), 32'h00003231);
        check("pend_b2b",   cyc_at(1) - cyc_at(0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
